// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch path: default widths, the NOP
// encoding and the fetch FSM states.
package cpu_pkg;
    localparam int          XLEN_DEF  = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Control, program-load and instruction-output signals of the fetch unit.
// The slave side is the fetch unit; the master side is the pipeline or loader.
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int IMEM_DEPTH = 256
);
    logic                          stall;
    logic                          redirect;
    logic [XLEN-1:0]               redirect_pc;
    logic                          load_en;
    logic [$clog2(IMEM_DEPTH)-1:0] load_addr;
    logic [31:0]                   load_data;
    logic [31:0]                   instr;
    logic [XLEN-1:0]               instr_pc;
    logic                          instr_valid;
    logic                          fault;
    logic [XLEN-1:0]               fault_pc;
    logic [31:0]                   fetch_count;

    modport master (
        output stall, redirect, redirect_pc, load_en, load_addr, load_data,
        input  instr, instr_pc, instr_valid, fault, fault_pc, fetch_count
    );

    modport slave (
        input  stall, redirect, redirect_pc, load_en, load_addr, load_data,
        output instr, instr_pc, instr_valid, fault, fault_pc, fetch_count
    );
endinterface

// File: rtl/instr_mem.sv
// Instruction RAM: one synchronous read port, one write port. A read of the
// word being written in the same cycle returns the previous contents.
module instr_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [31:0]              i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [31:0]              o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC with stall hold, redirect squash,
// sticky misaligned-redirect fault, and a delivered-instruction counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter int              IMEM_DEPTH = 256,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.slave  bus
);
    localparam int AW = $clog2(IMEM_DEPTH);

    fetch_state_t    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, r_instr_pc, r_fault_pc;
    logic            r_valid, r_fault, r_nop;
    logic [31:0]     r_count, w_rdata;
    logic            w_fetch, w_redir, w_fault_set, w_consume;

    always_ff @(posedge clk) begin
        if (rst) r_state <= FILL;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL, RUN: begin
                if (bus.redirect)
                    w_state_nxt = is_misaligned(bus.redirect_pc[1:0]) ? HALT : FILL;
                else if (!bus.stall)
                    w_state_nxt = RUN;
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = FILL;
        endcase
    end

    // Redirect wins over stall; only FILL/RUN react to the control inputs.
    always_comb begin
        w_fetch     = 1'b0;
        w_redir     = 1'b0;
        w_fault_set = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            FILL, RUN: begin
                if (bus.redirect) begin
                    w_redir     = 1'b1;
                    w_fault_set = is_misaligned(bus.redirect_pc[1:0]);
                end else if (!bus.stall) begin
                    w_fetch   = 1'b1;
                    w_consume = r_valid;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_instr_pc <= RESET_PC;
            r_valid    <= 1'b0;
            r_nop      <= 1'b1;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
            r_count    <= '0;
        end else begin
            if (w_redir) begin
                r_pc    <= bus.redirect_pc;
                r_valid <= 1'b0;
            end else if (w_fetch) begin
                r_pc       <= r_pc + XLEN'(4);
                r_instr_pc <= r_pc;
                r_valid    <= 1'b1;
                r_nop      <= 1'b0;
            end
            if (w_fault_set) begin
                r_fault    <= 1'b1;
                r_fault_pc <= bus.redirect_pc;
            end
            if (w_consume && r_count != 32'hFFFF_FFFF)
                r_count <= r_count + 32'd1;
        end
    end

    // The RAM output register holds while no read is issued, so a stall
    // keeps the delivered word without a separate instruction register.
    instr_mem #(.DEPTH(IMEM_DEPTH)) u_mem (
        .clk     (clk),
        .i_we    (bus.load_en),
        .i_waddr (bus.load_addr),
        .i_wdata (bus.load_data),
        .i_re    (w_fetch && !rst),
        .i_raddr (r_pc[AW+1:2]),
        .o_rdata (w_rdata)
    );

    assign bus.instr       = r_nop ? NOP_INSTR : w_rdata;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
    assign bus.fault       = r_fault;
    assign bus.fault_pc    = r_fault_pc;
    assign bus.fetch_count = r_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall, redirect, fault,
// load hazard, reset recovery and address wrap on a 4-word memory.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst0, rst1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32), .IMEM_DEPTH(256)) b0 ();
    fetch_unit_if #(.XLEN(32), .IMEM_DEPTH(4))   b1 ();

    fetch_unit #(.XLEN(32), .IMEM_DEPTH(256), .RESET_PC(32'h0)) u0 (
        .clk (clk), .rst (rst0), .bus (b0.slave));
    fetch_unit #(.XLEN(32), .IMEM_DEPTH(4), .RESET_PC(32'h0)) u1 (
        .clk (clk), .rst (rst1), .bus (b1.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic out0(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] cnt);
        chk({tag, ".valid"}, 64'(b0.instr_valid), 64'(v));
        if (v) begin
            chk({tag, ".pc"},    64'(b0.instr_pc), 64'(pc));
            chk({tag, ".instr"}, 64'(b0.instr),    64'(ins));
        end
        chk({tag, ".count"}, 64'(b0.fetch_count), 64'(cnt));
    endtask

    task automatic load0(input logic [7:0] a, input logic [31:0] d);
        b0.load_en = 1'b1; b0.load_addr = a; b0.load_data = d;
        tick();
        b0.load_en = 1'b0;
    endtask

    task automatic load1(input logic [1:0] a, input logic [31:0] d);
        b1.load_en = 1'b1; b1.load_addr = a; b1.load_data = d;
        tick();
        b1.load_en = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        b0.stall = 0; b0.redirect = 0; b0.redirect_pc = '0;
        b0.load_en = 0; b0.load_addr = '0; b0.load_data = '0;
        b1.stall = 0; b1.redirect = 0; b1.redirect_pc = '0;
        b1.load_en = 0; b1.load_addr = '0; b1.load_data = '0;

        // Program load while held in reset
        load0(8'd0,  32'h0010_0093);
        load0(8'd1,  32'h0020_0113);
        load0(8'd2,  32'h0030_0193);
        load0(8'd3,  32'h0040_0213);
        load0(8'd4,  32'h0050_0293);
        load0(8'd16, 32'h0AA0_0513);

        chk("rst.instr",    64'(b0.instr),       64'h13);
        chk("rst.pc",       64'(b0.instr_pc),    64'h0);
        chk("rst.valid",    64'(b0.instr_valid), 64'h0);
        chk("rst.fault",    64'(b0.fault),       64'h0);
        chk("rst.fault_pc", 64'(b0.fault_pc),    64'h0);
        chk("rst.count",    64'(b0.fetch_count), 64'h0);

        rst0 = 1'b0;
        tick(); out0("seq0", 1, 32'h0, 32'h0010_0093, 0);
        tick(); out0("seq1", 1, 32'h4, 32'h0020_0113, 1);

        b0.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); out0("stall", 1, 32'h4, 32'h0020_0113, 1);
        end
        b0.stall = 1'b0;
        tick(); out0("seq2", 1, 32'h8,  32'h0030_0193, 2);
        tick(); out0("seq3", 1, 32'hC,  32'h0040_0213, 3);
        tick(); out0("seq4", 1, 32'h10, 32'h0050_0293, 4);

        // Redirect beats a simultaneous stall
        b0.redirect = 1'b1; b0.redirect_pc = 32'h40; b0.stall = 1'b1;
        tick(); out0("redir.bubble", 0, 0, 0, 4);
        b0.redirect = 1'b0; b0.stall = 1'b0;
        tick(); out0("redir.tgt", 1, 32'h40, 32'h0AA0_0513, 4);

        // Load hazard: write word 2 in the cycle it is read
        b0.redirect = 1'b1; b0.redirect_pc = 32'h8;
        tick(); out0("haz.bubble", 0, 0, 0, 4);
        b0.redirect = 1'b0;
        b0.load_en = 1'b1; b0.load_addr = 8'd2; b0.load_data = 32'h0BB0_0593;
        tick(); out0("haz.old", 1, 32'h8, 32'h0030_0193, 4);
        b0.load_en = 1'b0;
        b0.redirect = 1'b1; b0.redirect_pc = 32'h8;
        tick();
        b0.redirect = 1'b0;
        tick(); out0("haz.new", 1, 32'h8, 32'h0BB0_0593, 4);

        // Misaligned redirect halts; control ignored, load still works
        b0.redirect = 1'b1; b0.redirect_pc = 32'h42;
        tick();
        chk("halt.fault",    64'(b0.fault),       64'h1);
        chk("halt.fault_pc", 64'(b0.fault_pc),    64'h42);
        out0("halt.enter", 0, 0, 0, 4);
        b0.redirect_pc = 32'h40;
        b0.load_en = 1'b1; b0.load_addr = 8'd1; b0.load_data = 32'h0CC0_0613;
        for (int i = 0; i < 3; i++) begin
            b0.stall = (i == 1);
            tick();
            b0.load_en = 1'b0;
            chk("halt.hold_fault", 64'(b0.fault),    64'h1);
            chk("halt.hold_fpc",   64'(b0.fault_pc), 64'h42);
            out0("halt.hold", 0, 0, 0, 4);
        end

        // Reset overrides redirect/stall and clears the fault
        rst0 = 1'b1; b0.redirect = 1'b1; b0.redirect_pc = 32'h80; b0.stall = 1'b1;
        tick();
        chk("rst2.fault",    64'(b0.fault),    64'h0);
        chk("rst2.fault_pc", 64'(b0.fault_pc), 64'h0);
        chk("rst2.instr",    64'(b0.instr),    64'h13);
        chk("rst2.pc",       64'(b0.instr_pc), 64'h0);
        out0("rst2", 0, 0, 0, 0);
        rst0 = 1'b0; b0.redirect = 1'b0; b0.stall = 1'b0;
        tick(); out0("rst2.seq0", 1, 32'h0, 32'h0010_0093, 0);
        tick(); out0("rst2.seq1", 1, 32'h4, 32'h0CC0_0613, 1);

        // Address wrap on a 4-word memory
        load1(2'd0, 32'h00A0_0093);
        load1(2'd1, 32'h00B0_0113);
        load1(2'd2, 32'h00C0_0193);
        load1(2'd3, 32'h00D0_0213);
        rst1 = 1'b0;
        tick();
        chk("wrap0.pc",    64'(b1.instr_pc), 64'h0);
        chk("wrap0.instr", 64'(b1.instr),    64'h00A0_0093);
        tick(); tick(); tick();
        chk("wrap12.pc",    64'(b1.instr_pc), 64'hC);
        chk("wrap12.instr", 64'(b1.instr),    64'h00D0_0213);
        tick();
        chk("wrap16.valid", 64'(b1.instr_valid), 64'h1);
        chk("wrap16.pc",    64'(b1.instr_pc),    64'h10);
        chk("wrap16.instr", 64'(b1.instr),       64'h00A0_0093);
        chk("wrap16.count", 64'(b1.fetch_count), 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath and PC width.
REQ-002 The block SHALL have parameter IMEM_DEPTH, default 256, meaning instruction memory depth in 32-bit words (power of two, >=4).
REQ-003 The block SHALL have parameter RESET_PC, default 0, meaning PC value after reset (word-aligned).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port stall  input  1  downstream not ready; hold the current output instruction.
REQ-007 The block SHALL have port redirect  input  1  taken branch/jump (pc_source from control).
REQ-008 The block SHALL have port redirect_pc  input  XLEN  target address for redirect.
REQ-009 The block SHALL have port load_en  input  1  program-load write strobe.
REQ-010 The block SHALL have port load_addr  input  $clog2(IMEM_DEPTH)  program-load word index.
REQ-011 The block SHALL have port load_data  input  32  program-load word.
REQ-012 The block SHALL have port instr  output  32  fetched instruction.
REQ-013 The block SHALL have port instr_pc  output  XLEN  address of instr.
REQ-014 The block SHALL have port instr_valid  output  1  instr/instr_pc are valid.
REQ-015 The block SHALL have port fault  output  1  misaligned-redirect fault, sticky.
REQ-016 The block SHALL have port fault_pc  output  XLEN  offending redirect target.
REQ-017 The block SHALL have port fetch_count  output  32  count of delivered instructions.

Function
REQ-018 The block SHALL implement states FILL (fetch in flight, output invalid), RUN (output valid) and HALT (fetch stopped).
REQ-019 Memory read SHALL be synchronous, one-cycle latency, word index = pc[$clog2(IMEM_DEPTH)+1:2]; upper PC bits are ignored (address wraps modulo IMEM_DEPTH*4).
REQ-020 In FILL or RUN with stall=0 and redirect=0: read issued at pc, pc <= pc+4 (modulo 2^XLEN), next cycle instr=mem[old pc], instr_pc=old pc, instr_valid=1, state RUN.
REQ-021 With stall=1 and redirect=0: pc, instr, instr_pc, instr_valid, state SHALL hold unchanged.
REQ-022 Redirect SHALL take priority over stall: pc <= redirect_pc, in-flight fetch squashed, instr_valid=0 next cycle, state FILL; first instruction from target valid two cycles after redirect.
REQ-023 Redirect with redirect_pc[1:0]!=0: state HALT, fault=1, fault_pc=redirect_pc, instr_valid=0 next cycle.
REQ-024 HALT SHALL be left only by rst; redirect, stall and fetch ignored in HALT; load port stays active.
REQ-025 fetch_count SHALL increment by 1 each cycle instr_valid=1 and stall=0 and redirect=0, saturating at 32'hFFFF_FFFF.
REQ-026 load_en SHALL write mem[load_addr]=load_data in any state; a same-cycle read of that word returns the old data.
REQ-027 Memory contents SHALL NOT be cleared by rst.

Reset
REQ-028 On rst=1 at a clock edge: pc=RESET_PC, state FILL, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC, instr_valid=0, fault=0, fault_pc=0, fetch_count=0.
REQ-029 rst SHALL override redirect, stall and any in-flight fetch; load_en in the same cycle SHALL still write.
REQ-030 First valid instruction (mem[RESET_PC]) SHALL appear the cycle after rst deasserts.

Structure
REQ-031 Shared package cpu_pkg SHALL hold XLEN default, the NOP constant 32'h0000_0013 and enum fetch_state_t {FILL, RUN, HALT}.
REQ-032 The RAM SHALL be a sub-module instr_mem (one synchronous read port, one write port, parameter DEPTH).

Verification
REQ-033 Load mem[0..3]=0x00100093,0x00200113,0x00300193,0x00400213, release rst -> instr_valid cycles 1..4 with instr_pc 0,4,8,12 and matching words; fetch_count=4.
REQ-034 Stall high for 3 cycles while instr_pc=4 -> instr/instr_pc held at 0x00200113/4 for 3 cycles, fetch_count unchanged, resumes at 8.
REQ-035 Redirect to 0x40 with stall=1 -> next cycle instr_valid=0, following cycle instr_pc=0x40, instr=mem[16].
REQ-036 Redirect to 0x42 -> fault=1, fault_pc=0x42, instr_valid=0 forever; later rst -> fault=0, fetch from RESET_PC.
REQ-037 IMEM_DEPTH=4, run from 0 -> instr_pc 0,4,8,12,16 with instr at 16 equal to mem[0] (wrap).
REQ-038 load_en to word 2 in the cycle pc=8 is read -> old word delivered; refetch after redirect to 8 delivers new word.
